// File: rtl/buzzer_tone_sequencer.sv
// Button-triggered buzzer tone sequencer: queues per-channel requests and plays each as a
// fixed-length square-wave beep followed by a silent gap. Optional feature: BUZZER_HOLD_EN.
module buzzer_tone_sequencer #(
    parameter int unsigned            N_CH        = 4,
    parameter int unsigned            CNT_W       = 20,
    parameter logic [N_CH*CNT_W-1:0]  TONE_HALF   = {20'd47_778, 20'd42_566, 20'd37_921,
                                                     20'd35_793},
    parameter int unsigned            DUR_W       = 26,
    parameter int unsigned            BEEP_CYCLES = 5_000_000,
    parameter int unsigned            GAP_CYCLES  = 1_000_000
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          enable,
    input  logic [N_CH-1:0]                               btn_trig,
    output logic                                          buzzer_out,
    output logic                                          busy,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]    active_ch
);

    localparam int unsigned AW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

    state_e            r_state;
    logic [N_CH-1:0]   r_btn_prev;
    logic [N_CH-1:0]   r_pend;
    logic [AW-1:0]     r_active;
    logic              r_buzz;
    logic              r_busy;
    logic [CNT_W-1:0]  r_half;
    logic [DUR_W-1:0]  r_dur;

    logic [N_CH-1:0]   w_edge;
    logic [N_CH-1:0]   w_req;
    logic [N_CH-1:0]   w_sel_oh;
    logic [N_CH-1:0]   w_pend_nxt;
    logic [AW-1:0]     w_sel;
    logic              w_found;
    logic [CNT_W-1:0]  w_half;
    logic              w_half_end;
    logic              w_beep_end;
    logic              w_gap_end;
    logic              w_hold;

    assign w_edge = btn_trig & ~r_btn_prev;
    assign w_req  = r_pend | w_edge;

    // Lowest-index request wins.
    always_comb begin
        w_sel    = '0;
        w_sel_oh = '0;
        w_found  = |w_req;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_sel       = AW'(i);
                w_sel_oh    = '0;
                w_sel_oh[i] = 1'b1;
            end
        end
    end

    // A fresh edge on an already-pending channel survives the clear.
    assign w_pend_nxt = (w_req & ~w_sel_oh) | (r_pend & w_edge);

    always_comb begin
        w_half = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (r_active == AW'(i)) begin
                w_half = TONE_HALF[i*CNT_W +: CNT_W];
            end
        end
    end

`ifdef BUZZER_HOLD_EN
    // Hold covers the cycle the button was last seen high, so the countdown starts on release.
    assign w_hold = btn_trig[r_active] | r_btn_prev[r_active];
`else
    assign w_hold = 1'b0;
`endif

    assign w_half_end = (r_half == w_half - CNT_W'(1));
    assign w_beep_end = !w_hold && (r_dur == DUR_W'(BEEP_CYCLES - 1));
    assign w_gap_end  = (r_dur == DUR_W'(GAP_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_btn_prev <= '0;
            r_pend     <= '0;
            r_active   <= '0;
            r_buzz     <= 1'b0;
            r_busy     <= 1'b0;
            r_half     <= '0;
            r_dur      <= '0;
        end else begin
            r_btn_prev <= btn_trig;
            if (!enable) begin
                r_state <= StIdle;
                r_pend  <= '0;
                r_buzz  <= 1'b0;
                r_busy  <= 1'b0;
                r_half  <= '0;
                r_dur   <= '0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_pend <= w_pend_nxt;
                        if (w_found) begin
                            r_state  <= StPlay;
                            r_active <= w_sel;
                            r_buzz   <= 1'b1;
                            r_busy   <= 1'b1;
                            r_half   <= '0;
                            r_dur    <= '0;
                        end
                    end
                    StPlay: begin
                        r_pend <= r_pend | w_edge;
                        if (w_beep_end) begin
                            r_state <= StGap;
                            r_buzz  <= 1'b0;
                            r_half  <= '0;
                            r_dur   <= '0;
                        end else begin
                            r_dur <= w_hold ? '0 : r_dur + DUR_W'(1);
                            if (w_half_end) begin
                                r_buzz <= ~r_buzz;
                                r_half <= '0;
                            end else begin
                                r_half <= r_half + CNT_W'(1);
                            end
                        end
                    end
                    StGap: begin
                        if (w_gap_end) begin
                            r_pend <= w_pend_nxt;
                            r_half <= '0;
                            r_dur  <= '0;
                            if (w_found) begin
                                r_state  <= StPlay;
                                r_active <= w_sel;
                                r_buzz   <= 1'b1;
                            end else begin
                                r_state <= StIdle;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_pend <= r_pend | w_edge;
                            r_dur  <= r_dur + DUR_W'(1);
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                        r_buzz  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign buzzer_out = r_buzz;
    assign busy       = r_busy;
    assign active_ch  = r_active;

endmodule

// File: tb/tb_buzzer_tone_sequencer.sv
// Directed self-checking bench for buzzer_tone_sequencer (2 channels, short tones and gaps).
module tb_buzzer_tone_sequencer;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [1:0] btn_trig;
    logic       buzzer_out;
    logic       busy;
    logic [0:0] active_ch;

    int n_chk = 0;
    int n_err = 0;

    buzzer_tone_sequencer #(
        .N_CH        (2),
        .CNT_W       (20),
        .TONE_HALF   ({20'd3, 20'd5}),
        .DUR_W       (26),
        .BEEP_CYCLES (20),
        .GAP_CYCLES  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .btn_trig   (btn_trig),
        .buzzer_out (buzzer_out),
        .busy       (busy),
        .active_ch  (active_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called with the entry edge just taken; samples 20 PLAY + 4 GAP cycles, ends on cycle 24.
    task automatic check_beep(input string tag, input int ch, input int half,
                              input logic [23:0] pulse1);
        logic [23:0] ob;
        logic [23:0] oy;
        logic [23:0] eb;
        int          bad_ch;
        bad_ch = 0;
        for (int j = 0; j < 24; j++) begin
            ob[j] = buzzer_out;
            oy[j] = busy;
            eb[j] = (j < 20) && (((j / half) % 2) == 0);
            if (int'(active_ch) != ch) bad_ch++;
            btn_trig[1] = pulse1[j];
            tick();
        end
        check_eq({tag, "_buzz"}, 32'(ob), 32'(eb));
        check_eq({tag, "_busy"}, 32'(oy), 32'h00FF_FFFF);
        check_eq({tag, "_ch_err"}, 32'(bad_ch), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b1;
        btn_trig = 2'b00;
        tick();
        tick();
        check_eq("rst_buzz", 32'(buzzer_out), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ch", 32'(active_ch), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("idle_busy", 32'(busy), 32'd0);

        // Single pulse on channel 0
        btn_trig = 2'b01;
        tick();
        btn_trig = 2'b00;
        check_beep("t1", 0, 5, 24'h0);
        check_eq("t1_idle", 32'(busy), 32'd0);
        tick();
        check_eq("t1_idle_buzz", 32'(buzzer_out), 32'd0);

        // Both channels rise together: ch0, gap, ch1, idle
        btn_trig = 2'b11;
        tick();
        btn_trig = 2'b00;
        check_beep("t2a", 0, 5, 24'h0);
        check_beep("t2b", 1, 3, 24'h0);
        check_eq("t2_idle", 32'(busy), 32'd0);
        check_eq("t2_ch_hold", 32'(active_ch), 32'd1);

        // Two re-triggers of the playing channel: no restart, one extra beep
        tick();
        btn_trig = 2'b10;
        tick();
        btn_trig = 2'b00;
        check_beep("t3a", 1, 3, 24'h000408);
        check_beep("t3b", 1, 3, 24'h0);
        check_eq("t3_idle", 32'(busy), 32'd0);

        // Disable at PLAY cycle 7 with ch1 pending; re-enable while ch0 held
        tick();
        btn_trig = 2'b01;
        tick();
        btn_trig = 2'b00;
        for (int j = 0; j < 7; j++) begin
            btn_trig[1] = (j == 2);
            tick();
        end
        check_eq("t4_busy_pre", 32'(busy), 32'd1);
        enable      = 1'b0;
        btn_trig[0] = 1'b1;
        tick();
        check_eq("t4_off_buzz", 32'(buzzer_out), 32'd0);
        check_eq("t4_off_busy", 32'(busy), 32'd0);
        tick();
        tick();
        check_eq("t4_ignored", 32'(busy), 32'd0);
        enable = 1'b1;
        tick();
        tick();
        tick();
        check_eq("t4_no_beep", 32'(busy), 32'd0);
        check_eq("t4_no_buzz", 32'(buzzer_out), 32'd0);
        btn_trig = 2'b00;
        tick();

        // Asynchronous reset in the middle of a ch1 gap
        btn_trig = 2'b10;
        tick();
        btn_trig = 2'b00;
        for (int j = 0; j < 21; j++) tick();
        check_eq("t5_gap_busy", 32'(busy), 32'd1);
        check_eq("t5_gap_ch", 32'(active_ch), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_async_busy", 32'(busy), 32'd0);
        check_eq("t5_async_buzz", 32'(buzzer_out), 32'd0);
        check_eq("t5_async_ch", 32'(active_ch), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        btn_trig = 2'b01;
        tick();
        btn_trig = 2'b00;
        check_beep("t5", 0, 5, 24'h0);
        check_eq("t5_idle", 32'(busy), 32'd0);

`ifdef BUZZER_HOLD_EN
        // Hold channel 0 for 50 cycles: PLAY lasts 70 cycles from the edge
        tick();
        btn_trig = 2'b01;
        tick();
        for (int j = 0; j < 74; j++) begin
            if (j == 49) btn_trig = 2'b00;
            if (j == 69) check_eq("t6_play_end", 32'(busy), 32'd1);
            tick();
            if (j == 69) check_eq("t6_gap_buzz", 32'(buzzer_out), 32'd0);
        end
        check_eq("t6_idle", 32'(busy), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
